loop_table_sequencer: RTL and testbench

- Configures and launches the loop-nest FSM.
- Owns the state table: DEPTH x ENTRY_W register file, read combinationally by the FSM's smart_ptr.
- Loads programs from a host config stream and appends an invalid terminator entry.
- Drives the FSM's start_inbound / start_stream_in 4-phase handshake, then waits for done; one program may be relaunched many times without reloading.

---
 rtl/loop_table_sequencer_pkg.sv | 34 +++
 rtl/loop_table_sequencer_rf.sv | 32 +++
 rtl/loop_table_sequencer.sv | 139 +++++++++++++
 tb/tb_loop_table_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/loop_table_sequencer_pkg.sv
// Shared widths, state-table entry layout and sequencer state encoding
// for the loop-nest table sequencer.
package loop_table_sequencer_pkg;

    localparam int ENTRY_W = 48;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 16;
    localparam int DEPTH   = 2 ** ADDR_W;

    // Entry layout; an all-zero entry (valid = 0) terminates a program.
    localparam int VALID_BIT        = 47;
    localparam int LEVEL_LSB        = 40;
    localparam int SC_LSB           = 32;
    localparam int NUM_SC_LSB       = 24;
    localparam int TYPE_LSB         = 16;
    localparam int TRIGGERED_ON_LSB = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_TERM,
        S_DRAIN,
        S_LOADED,
        S_ARM,
        S_HS_REQ,
        S_HS_REL,
        S_RUN
    } seq_state_e;

    function automatic logic entry_valid(input logic [ENTRY_W-1:0] entry);
        return entry[VALID_BIT];
    endfunction

endpackage

// File: rtl/loop_table_sequencer_rf.sv
// State-table register file: synchronous write and clear, combinational
// read port for the loop-nest FSM.
module loop_table_rf #(
    parameter int ENTRY_W = 48,
    parameter int ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/loop_table_sequencer.sv
// Loads loop-nest programs into the state table and launches the FSM
// through its start_inbound / start_stream_in handshake.
module loop_table_sequencer
    import loop_table_sequencer_pkg::*;
#(
    parameter int ENTRY_W = loop_table_sequencer_pkg::ENTRY_W,
    parameter int ADDR_W  = loop_table_sequencer_pkg::ADDR_W,
    parameter int CNT_W   = loop_table_sequencer_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ENTRY_W-1:0] cfg_tdata,
    input  logic               cfg_tvalid,
    input  logic               cfg_tlast,
    output logic               cfg_tready,
    input  logic               launch,
    input  logic [ADDR_W-1:0]  table_rd_addr,
    output logic [ENTRY_W-1:0] entry_table,
    output logic               start_inbound,
    output logic               start_stream_in,
    input  logic               fsm_ready_stream_in,
    input  logic               fsm_done,
    output logic               busy,
    output logic               loaded,
    output logic               load_err,
    output logic [CNT_W-1:0]   run_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2 ** ADDR_W - 1);

    seq_state_e         state, state_next;
    logic [ADDR_W-1:0]  wr_ptr, wr_ptr_next;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ENTRY_W-1:0] wr_data;
    logic               beat, clr_load, set_loaded, set_err, cnt_inc;

    // Launch takes priority over a simultaneous config beat in LOADED.
    assign cfg_tready = !rst &&
                        (state == S_IDLE || state == S_LOAD || state == S_DRAIN ||
                         (state == S_LOADED && !launch));
    assign beat = cfg_tvalid && cfg_tready;

    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr;
        wr_data     = cfg_tdata;
        clr_load    = 1'b0;
        set_loaded  = 1'b0;
        set_err     = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            S_IDLE, S_LOADED: begin
                if (state == S_LOADED && launch) begin
                    state_next = S_ARM;
                end else if (beat) begin
                    wr_en       = 1'b1;
                    wr_addr     = '0;
                    wr_ptr_next = ADDR_W'(1);
                    clr_load    = 1'b1;
                    state_next  = cfg_tlast ? S_TERM : S_LOAD;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    // The last slot is reserved for the terminator entry.
                    if (wr_ptr == LAST_ADDR) begin
                        set_err    = 1'b1;
                        state_next = cfg_tlast ? S_IDLE : S_DRAIN;
                    end else begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr + 1'b1;
                        if (cfg_tlast) state_next = S_TERM;
                    end
                end
            end
            S_TERM: begin
                wr_en      = 1'b1;
                wr_data    = '0;
                set_loaded = 1'b1;
                state_next = S_LOADED;
            end
            S_DRAIN:  if (beat && cfg_tlast) state_next = S_IDLE;
            S_ARM:    state_next = S_HS_REQ;
            S_HS_REQ: if (fsm_ready_stream_in) state_next = S_HS_REL;
            S_HS_REL: state_next = S_RUN;
            S_RUN: begin
                if (fsm_done) begin
                    cnt_inc    = 1'b1;
                    state_next = S_LOADED;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            wr_ptr          <= '0;
            start_inbound   <= 1'b0;
            start_stream_in <= 1'b0;
            busy            <= 1'b0;
            loaded          <= 1'b0;
            load_err        <= 1'b0;
            run_count       <= '0;
        end else begin
            state           <= state_next;
            wr_ptr          <= wr_ptr_next;
            start_inbound   <= (state_next == S_ARM);
            start_stream_in <= (state_next == S_HS_REQ);
            busy            <= (state_next == S_ARM) || (state_next == S_HS_REQ) ||
                               (state_next == S_HS_REL) || (state_next == S_RUN);
            if (clr_load)        loaded <= 1'b0;
            else if (set_loaded) loaded <= 1'b1;
            if (clr_load)        load_err <= 1'b0;
            else if (set_err)    load_err <= 1'b1;
            if (clr_load)        run_count <= '0;
            else if (cnt_inc)    run_count <= run_count + 1'b1;
        end
    end

    loop_table_rf #(
        .ENTRY_W (ENTRY_W),
        .ADDR_W  (ADDR_W)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (table_rd_addr),
        .rd_data (entry_table)
    );

endmodule

// File: tb/tb_loop_table_sequencer.sv
// Scoreboard bench for loop_table_sequencer: program loads, launches with an
// FSM handshake model, overflow, launch/beat collision and mid-run reset.
module tb_loop_table_sequencer;
    import loop_table_sequencer_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [ENTRY_W-1:0] cfg_tdata;
    logic               cfg_tvalid, cfg_tlast, cfg_tready;
    logic               launch;
    logic [ADDR_W-1:0]  table_rd_addr;
    logic [ENTRY_W-1:0] entry_table;
    logic               start_inbound, start_stream_in;
    logic               fsm_ready_stream_in, fsm_done;
    logic               busy, loaded, load_err;
    logic [CNT_W-1:0]   run_count;

    int errors = 0;
    int checks = 0;
    int runs   = 0;
    logic [ENTRY_W-1:0] exp_q [$];
    logic [CNT_W-1:0]   cnt_q [$];
    logic [ENTRY_W-1:0] prog  [DEPTH];

    always #5 clk = ~clk;

    loop_table_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .cfg_tdata           (cfg_tdata),
        .cfg_tvalid          (cfg_tvalid),
        .cfg_tlast           (cfg_tlast),
        .cfg_tready          (cfg_tready),
        .launch              (launch),
        .table_rd_addr       (table_rd_addr),
        .entry_table         (entry_table),
        .start_inbound       (start_inbound),
        .start_stream_in     (start_stream_in),
        .fsm_ready_stream_in (fsm_ready_stream_in),
        .fsm_done            (fsm_done),
        .busy                (busy),
        .loaded              (loaded),
        .load_err            (load_err),
        .run_count           (run_count)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ENTRY_W-1:0] rand_entry();
        return {1'b1, 15'($urandom), 32'($urandom)};
    endfunction

    task automatic send_beat(input logic [ENTRY_W-1:0] d, input logic last);
        cfg_tdata  = d;
        cfg_tvalid = 1'b1;
        cfg_tlast  = last;
        #1;
        check_val("cfg_tready_on_beat", cfg_tready, 1);
        tick();
        cfg_tvalid = 1'b0;
        cfg_tlast  = 1'b0;
    endtask

    task automatic verify_table(input int n);
        for (int i = 0; i < n; i++) begin
            table_rd_addr = ADDR_W'(i);
            #1;
            if (exp_q.size() == 0) begin
                check_val("scoreboard_empty", 1, 0);
            end else begin
                check_val($sformatf("entry[%0d]", i), entry_table, exp_q.pop_front());
            end
        end
    endtask

    // Launch (optionally colliding with a config beat), drive the FSM side of
    // the handshake, raise fsm_done after done_delay cycles in RUN.
    task automatic launch_and_run(input bit with_beat, input int done_delay);
        int si, ss, ovl;
        bit ended;
        launch = 1'b1;
        if (with_beat) begin
            cfg_tdata  = '1;
            cfg_tvalid = 1'b1;
            cfg_tlast  = 1'b1;
            #1;
            check_val("tready_on_launch", cfg_tready, 0);
        end
        tick();
        launch     = 1'b0;
        cfg_tvalid = 1'b0;
        cfg_tlast  = 1'b0;
        check_val("arm_start_inbound", start_inbound, 1);
        check_val("arm_start_stream", start_stream_in, 0);
        check_val("arm_busy", busy, 1);
        si = 1; ss = 0; ovl = 0; ended = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (start_inbound) si++;
            if (start_inbound && start_stream_in) ovl++;
            if (start_stream_in) begin
                ss++;
                if (ss == 3) fsm_ready_stream_in = 1'b1;
            end else begin
                ended = 1;
                break;
            end
        end
        fsm_ready_stream_in = 1'b0;
        check_val("hs_ended_in_budget", ended, 1);
        check_val("start_inbound_cycles", si, 1);
        check_val("start_stream_cycles", ss, 3);
        check_val("start_overlap", ovl, 0);
        for (int i = 0; i < done_delay; i++) tick();
        check_val("run_busy", busy, 1);
        check_val("run_count_before_done", run_count, CNT_W'(runs));
        fsm_done = 1'b1;
        runs++;
        cnt_q.push_back(CNT_W'(runs));
        tick();
        fsm_done = 1'b0;
        check_val("run_count", run_count, cnt_q.pop_front());
        check_val("done_busy", busy, 0);
        check_val("done_loaded", loaded, 1);
    endtask

    initial begin
        rst = 1'b1; cfg_tdata = '0; cfg_tvalid = 1'b0; cfg_tlast = 1'b0;
        launch = 1'b0; table_rd_addr = '0; fsm_ready_stream_in = 1'b0; fsm_done = 1'b0;
        #1;
        check_val("tready_in_reset", cfg_tready, 0);
        tick(); tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_loaded", loaded, 0);
        check_val("rst_load_err", load_err, 0);
        check_val("rst_run_count", run_count, 0);
        check_val("rst_start_inbound", start_inbound, 0);
        check_val("rst_start_stream", start_stream_in, 0);
        rst = 1'b0;
        #1;
        check_val("idle_tready", cfg_tready, 1);

        // 3-entry program
        for (int i = 0; i < 3; i++) begin
            prog[i] = rand_entry();
            exp_q.push_back(prog[i]);
            send_beat(prog[i], i == 2);
        end
        exp_q.push_back('0);
        check_val("loaded_after_last_beat", loaded, 0);
        tick();
        check_val("loaded_two_cycles", loaded, 1);
        verify_table(4);

        launch_and_run(1'b0, 10);
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        check_val("done_ignored_in_loaded", run_count, 1);
        launch_and_run(1'b0, 4);
        for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
        exp_q.push_back('0);
        verify_table(4);

        launch_and_run(1'b1, 3);
        for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
        exp_q.push_back('0);
        verify_table(4);

        // Overflow: 33 beats, only the first 31 fit
        for (int i = 0; i < 33; i++) begin
            logic [ENTRY_W-1:0] d;
            d = rand_entry();
            if (i < 31) exp_q.push_back(d);
            send_beat(d, i == 32);
            if (i == 0) begin
                check_val("reload_clears_loaded", loaded, 0);
                check_val("reload_clears_count", run_count, 0);
            end
            if (i == 30) check_val("no_err_at_31", load_err, 0);
            if (i == 31) check_val("err_at_32", load_err, 1);
        end
        runs = 0;
        check_val("ovf_loaded", loaded, 0);
        check_val("ovf_idle_tready", cfg_tready, 1);
        check_val("ovf_err_sticky", load_err, 1);
        exp_q.push_back('0);
        verify_table(32);

        prog[0] = rand_entry();
        exp_q.push_back(prog[0]);
        exp_q.push_back('0);
        send_beat(prog[0], 1'b1);
        check_val("new_load_clears_err", load_err, 0);
        tick();
        check_val("new_load_loaded", loaded, 1);
        verify_table(2);

        // Reset while waiting for ready_stream_in
        launch = 1'b1;
        tick();
        launch = 1'b0;
        tick();
        check_val("hsreq_start_stream", start_stream_in, 1);
        rst = 1'b1;
        tick();
        check_val("midrst_start_stream", start_stream_in, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_loaded", loaded, 0);
        check_val("midrst_tready", cfg_tready, 0);
        rst = 1'b0;
        #1;
        check_val("midrst_idle_tready", cfg_tready, 1);
        for (int i = 0; i < 32; i++) exp_q.push_back('0);
        verify_table(32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
